// File: rtl/lfsr_chk_pkg.sv
// Shared definitions for the 8-bit LFSR BIST read-back checker.
//   state_e     : checker FSM states (SYNC is only reachable when
//                 LFSR_CHK_SELFSYNC_EN is defined)
//   LFSR_SEED   : power-on / start value of the expected-data generator
//   LFSR_TAPS   : feedback mask for taps 8,6,5,4 (bits 7,5,4,3)
//   lfsr_next() : one left-shift step, feedback into bit 0
package lfsr_chk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SYNC  = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam logic [7:0] LFSR_SEED = 8'h01;
  localparam logic [7:0] LFSR_TAPS = 8'hB8;

  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    return {v[6:0], ^(v & LFSR_TAPS)};
  endfunction

endpackage

// File: rtl/lfsr_8b_checker_if.sv
// Bus bundle between the BIST controller / read path and the checker.
//   start, len            : arm a run of len words
//   din_valid, din        : read-back word stream (no backpressure)
//   busy, done, pass      : run status
//   err_cnt, first_err_*  : mismatch count and first-failure capture
// master = controller/stimulus side, slave = checker.
interface lfsr_8b_checker_if #(
  parameter int LEN_W = 10,
  parameter int CNT_W = 8
);
  logic             start;
  logic [LEN_W-1:0] len;
  logic             din_valid;
  logic [7:0]       din;
  logic             busy;
  logic             done;
  logic             pass;
  logic [CNT_W-1:0] err_cnt;
  logic [LEN_W-1:0] first_err_idx;
  logic [7:0]       first_err_data;
  logic [7:0]       first_err_exp;

  modport master (
    output start, len, din_valid, din,
    input  busy, done, pass, err_cnt, first_err_idx, first_err_data, first_err_exp
  );

  modport slave (
    input  start, len, din_valid, din,
    output busy, done, pass, err_cnt, first_err_idx, first_err_data, first_err_exp
  );
endinterface

// File: rtl/lfsr_8b_exp.sv
// Expected-value register for the checker.
//   clk, rstn : clock, synchronous active-low reset (resets to LFSR_SEED)
//   load      : load load_val (wins over advance)
//   load_val  : value to load
//   advance   : step the LFSR one position
//   exp       : current expected word
module lfsr_8b_exp
  import lfsr_chk_pkg::*;
(
  input  logic       clk,
  input  logic       rstn,
  input  logic       load,
  input  logic [7:0] load_val,
  input  logic       advance,
  output logic [7:0] exp
);

  always_ff @(posedge clk) begin
    if (!rstn)        exp <= LFSR_SEED;
    else if (load)    exp <= load_val;
    else if (advance) exp <= lfsr_next(exp);
  end

endmodule

// File: rtl/lfsr_8b_checker.sv
// Receive-side LFSR pattern checker for the memory BIST path.
// Regenerates the 8-bit LFSR sequence, compares it with read-back words,
// counts mismatches (saturating) and captures the first failing word.
//   clk, rstn : clock, synchronous active-low reset
//   bus       : lfsr_8b_checker_if.slave (start/len, din stream, results)
// Optional: define LFSR_CHK_SELFSYNC_EN to let the first valid word seed
// the generator (SYNC state) instead of being compared against 8'h01.
module lfsr_8b_checker
  import lfsr_chk_pkg::*;
#(
  parameter int LEN_W = 10,
  parameter int CNT_W = 8
) (
  input  logic                clk,
  input  logic                rstn,
  lfsr_8b_checker_if.slave    bus
);

  state_e           state, state_nxt;
  logic [LEN_W-1:0] len_r, len_nxt;
  logic [LEN_W-1:0] idx, idx_nxt;
  logic [CNT_W-1:0] err_r, err_nxt;
  logic             cap_r, cap_nxt;
  logic [LEN_W-1:0] fe_idx, fe_idx_nxt;
  logic [7:0]       fe_data, fe_data_nxt;
  logic [7:0]       fe_exp, fe_exp_nxt;
  logic             busy_r, done_r, done_nxt, pass_r, pass_nxt;
  logic             exp_load, exp_adv;
  logic [7:0]       exp_val, exp;

  lfsr_8b_exp u_exp (
    .clk      (clk),
    .rstn     (rstn),
    .load     (exp_load),
    .load_val (exp_val),
    .advance  (exp_adv),
    .exp      (exp)
  );

  always_comb begin
    state_nxt   = state;
    len_nxt     = len_r;
    idx_nxt     = idx;
    err_nxt     = err_r;
    cap_nxt     = cap_r;
    fe_idx_nxt  = fe_idx;
    fe_data_nxt = fe_data;
    fe_exp_nxt  = fe_exp;
    pass_nxt    = pass_r;
    done_nxt    = 1'b0;
    exp_load    = 1'b0;
    exp_val     = LFSR_SEED;
    exp_adv     = 1'b0;
    case (state)
      ST_IDLE, ST_DONE: begin
        if (bus.start) begin
          len_nxt     = bus.len;
          idx_nxt     = '0;
          err_nxt     = '0;
          cap_nxt     = 1'b0;
          fe_idx_nxt  = '0;
          fe_data_nxt = '0;
          fe_exp_nxt  = '0;
          pass_nxt    = 1'b0;
          exp_load    = 1'b1;
          if (bus.len == '0) begin
            state_nxt = ST_DONE;
            done_nxt  = 1'b1;
            pass_nxt  = 1'b1;
          end else begin
`ifdef LFSR_CHK_SELFSYNC_EN
            state_nxt = ST_SYNC;
`else
            state_nxt = ST_CHECK;
`endif
          end
        end
      end
`ifdef LFSR_CHK_SELFSYNC_EN
      ST_SYNC: begin
        if (bus.din_valid) begin
          exp_load = 1'b1;
          idx_nxt  = idx + 1'b1;
          // 8'h00 would lock the LFSR up: treat it as a bad word against
          // the nominal seed and continue from the seed's successor.
          if (bus.din == 8'h00) begin
            err_nxt     = (err_r == '1) ? err_r : err_r + 1'b1;
            cap_nxt     = 1'b1;
            fe_idx_nxt  = idx;
            fe_data_nxt = bus.din;
            fe_exp_nxt  = LFSR_SEED;
            exp_val     = lfsr_next(LFSR_SEED);
          end else begin
            exp_val = lfsr_next(bus.din);
          end
          if (idx == len_r - 1'b1) begin
            state_nxt = ST_DONE;
            done_nxt  = 1'b1;
            pass_nxt  = (err_nxt == '0);
          end else begin
            state_nxt = ST_CHECK;
          end
        end
      end
`endif
      ST_CHECK: begin
        if (bus.din_valid) begin
          exp_adv = 1'b1;
          idx_nxt = idx + 1'b1;
          if (bus.din != exp) begin
            err_nxt = (err_r == '1) ? err_r : err_r + 1'b1;
            if (!cap_r) begin
              cap_nxt     = 1'b1;
              fe_idx_nxt  = idx;
              fe_data_nxt = bus.din;
              fe_exp_nxt  = exp;
            end
          end
          if (idx == len_r - 1'b1) begin
            state_nxt = ST_DONE;
            done_nxt  = 1'b1;
            pass_nxt  = (err_nxt == '0);
          end
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state   <= ST_IDLE;
      len_r   <= '0;
      idx     <= '0;
      err_r   <= '0;
      cap_r   <= 1'b0;
      fe_idx  <= '0;
      fe_data <= '0;
      fe_exp  <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      pass_r  <= 1'b0;
    end else begin
      state   <= state_nxt;
      len_r   <= len_nxt;
      idx     <= idx_nxt;
      err_r   <= err_nxt;
      cap_r   <= cap_nxt;
      fe_idx  <= fe_idx_nxt;
      fe_data <= fe_data_nxt;
      fe_exp  <= fe_exp_nxt;
      busy_r  <= (state_nxt == ST_SYNC) || (state_nxt == ST_CHECK);
      done_r  <= done_nxt;
      pass_r  <= pass_nxt;
    end
  end

  assign bus.busy           = busy_r;
  assign bus.done           = done_r;
  assign bus.pass           = pass_r;
  assign bus.err_cnt        = err_r;
  assign bus.first_err_idx  = fe_idx;
  assign bus.first_err_data = fe_data;
  assign bus.first_err_exp  = fe_exp;

endmodule

// File: tb/tb_lfsr_8b_checker.sv
// Directed self-checking bench for lfsr_8b_checker. Inputs are driven and
// outputs sampled on the falling edge; the DUT works on the rising edge.
// A second instance with CNT_W=2 covers counter saturation.
module tb_lfsr_8b_checker;

  logic clk = 1'b0;
  logic rstn;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  lfsr_8b_checker_if #(.LEN_W(10), .CNT_W(8)) bus ();
  lfsr_8b_checker_if #(.LEN_W(10), .CNT_W(2)) bus_s ();

  lfsr_8b_checker #(.LEN_W(10), .CNT_W(8)) u_dut (.clk(clk), .rstn(rstn), .bus(bus));
  lfsr_8b_checker #(.LEN_W(10), .CNT_W(2)) u_sat (.clk(clk), .rstn(rstn), .bus(bus_s));

  logic [7:0] seq [0:5] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11, 8'h23};

  task automatic start_run(input logic [9:0] l);
    bus.start = 1'b1;
    bus.len   = l;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  task automatic word(input logic [7:0] d);
    bus.din_valid = 1'b1;
    bus.din       = d;
    @(negedge clk);
    bus.din_valid = 1'b0;
  endtask

  task automatic test_reset;
    rstn = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.busy, bus.done, bus.pass} !== 3'b000) begin
      failures++; $display("FAIL reset_flags got=%b want=000", {bus.busy, bus.done, bus.pass});
    end
    checks++;
    if (bus.err_cnt !== 8'd0 || bus.first_err_idx !== 10'd0 ||
        bus.first_err_data !== 8'd0 || bus.first_err_exp !== 8'd0) begin
      failures++; $display("FAIL reset_regs got=%0h/%0h/%0h/%0h want=0", bus.err_cnt,
                           bus.first_err_idx, bus.first_err_data, bus.first_err_exp);
    end
    rstn = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_clean;
    start_run(10'd6);
    checks++;
    if (bus.busy !== 1'b1) begin
      failures++; $display("FAIL clean_busy got=%b want=1", bus.busy);
    end
    for (int i = 0; i < 6; i++) word(seq[i]);
    checks++;
    if ({bus.done, bus.pass, bus.busy} !== 3'b110 || bus.err_cnt !== 8'd0) begin
      failures++; $display("FAIL clean_done got=d%b p%b b%b e%0d want=d1 p1 b0 e0",
                           bus.done, bus.pass, bus.busy, bus.err_cnt);
    end
    @(negedge clk);
    checks++;
    if ({bus.done, bus.pass} !== 2'b01) begin
      failures++; $display("FAIL clean_pulse got=d%b p%b want=d0 p1", bus.done, bus.pass);
    end
    // words while in DONE must not move anything
    word(8'hAA); word(8'h55);
    checks++;
    if (bus.err_cnt !== 8'd0 || bus.pass !== 1'b1) begin
      failures++; $display("FAIL done_ignore got=e%0d p%b want=e0 p1", bus.err_cnt, bus.pass);
    end
  endtask

  task automatic test_single_error;
    start_run(10'd6);
    for (int i = 0; i < 6; i++) word(i == 3 ? 8'h09 : seq[i]);
    checks++;
    if (bus.done !== 1'b1 || bus.pass !== 1'b0 || bus.err_cnt !== 8'd1) begin
      failures++; $display("FAIL single_status got=d%b p%b e%0d want=d1 p0 e1",
                           bus.done, bus.pass, bus.err_cnt);
    end
    checks++;
    if (bus.first_err_idx !== 10'd3 || bus.first_err_data !== 8'h09 || bus.first_err_exp !== 8'h08) begin
      failures++; $display("FAIL single_capture got=i%0d d%0h x%0h want=i3 d09 x08",
                           bus.first_err_idx, bus.first_err_data, bus.first_err_exp);
    end
  endtask

  task automatic test_gapped;
    start_run(10'd6);
    for (int i = 0; i < 6; i++) begin
      if (i == 5) begin
        checks++;
        if (bus.done !== 1'b0 || bus.busy !== 1'b1) begin
          failures++; $display("FAIL gap_early got=d%b b%b want=d0 b1", bus.done, bus.busy);
        end
      end
      word(seq[i]);
      if (i < 5) begin
        // a start mid-run is ignored
        if (i == 2) begin
          bus.start = 1'b1; bus.len = 10'd1;
        end
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
      end
    end
    checks++;
    if ({bus.done, bus.pass} !== 2'b11 || bus.err_cnt !== 8'd0) begin
      failures++; $display("FAIL gap_done got=d%b p%b e%0d want=d1 p1 e0",
                           bus.done, bus.pass, bus.err_cnt);
    end
  endtask

  task automatic test_selfsync;
`ifdef LFSR_CHK_SELFSYNC_EN
    start_run(10'd4);
    word(8'h11); word(8'h23); word(8'h47); word(8'h8E);
    checks++;
    if ({bus.done, bus.pass} !== 2'b11 || bus.err_cnt !== 8'd0) begin
      failures++; $display("FAIL sync_clean got=d%b p%b e%0d want=d1 p1 e0",
                           bus.done, bus.pass, bus.err_cnt);
    end
    start_run(10'd4);
    word(8'h00); word(8'h02); word(8'h04); word(8'h08);
    checks++;
    if (bus.err_cnt !== 8'd1 || bus.first_err_idx !== 10'd0 || bus.first_err_data !== 8'h00 ||
        bus.first_err_exp !== 8'h01 || bus.pass !== 1'b0) begin
      failures++; $display("FAIL sync_zero got=e%0d i%0d d%0h x%0h p%b want=e1 i0 d00 x01 p0",
                           bus.err_cnt, bus.first_err_idx, bus.first_err_data, bus.first_err_exp, bus.pass);
    end
`else
    // without self-sync word 0 is compared against the seed
    start_run(10'd4);
    word(8'h11); word(8'h23); word(8'h47); word(8'h8E);
    checks++;
    if (bus.err_cnt !== 8'd4 || bus.first_err_idx !== 10'd0 || bus.first_err_data !== 8'h11 ||
        bus.first_err_exp !== 8'h01 || bus.pass !== 1'b0) begin
      failures++; $display("FAIL nosync_word0 got=e%0d i%0d d%0h x%0h p%b want=e4 i0 d11 x01 p0",
                           bus.err_cnt, bus.first_err_idx, bus.first_err_data, bus.first_err_exp, bus.pass);
    end
`endif
  endtask

  task automatic test_saturation;
    bus_s.start = 1'b1; bus_s.len = 10'd8;
    @(negedge clk);
    bus_s.start = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus_s.din_valid = 1'b1; bus_s.din = 8'hFF;
      @(negedge clk);
    end
    bus_s.din_valid = 1'b0;
    checks++;
    if (bus_s.err_cnt !== 2'd3 || bus_s.pass !== 1'b0 || bus_s.done !== 1'b1) begin
      failures++; $display("FAIL saturation got=e%0d p%b d%b want=e3 p0 d1",
                           bus_s.err_cnt, bus_s.pass, bus_s.done);
    end
  endtask

  task automatic test_reset_restart;
    start_run(10'd6);
    word(8'h01); word(8'h77); word(8'h04);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    checks++;
    if ({bus.busy, bus.done, bus.pass} !== 3'b000 || bus.err_cnt !== 8'd0 ||
        bus.first_err_idx !== 10'd0 || bus.first_err_data !== 8'd0 || bus.first_err_exp !== 8'd0) begin
      failures++; $display("FAIL midrun_reset got=b%b d%b p%b e%0d i%0d d%0h x%0h want=all0",
                           bus.busy, bus.done, bus.pass, bus.err_cnt, bus.first_err_idx,
                           bus.first_err_data, bus.first_err_exp);
    end
    start_run(10'd0);
    checks++;
    if ({bus.done, bus.pass, bus.busy} !== 3'b110) begin
      failures++; $display("FAIL len0_done got=d%b p%b b%b want=d1 p1 b0", bus.done, bus.pass, bus.busy);
    end
    @(negedge clk);
    checks++;
    if ({bus.done, bus.pass} !== 2'b01) begin
      failures++; $display("FAIL len0_pulse got=d%b p%b want=d0 p1", bus.done, bus.pass);
    end
  endtask

  initial begin
    rstn = 1'b0;
    bus.start = 1'b0; bus.len = '0; bus.din_valid = 1'b0; bus.din = '0;
    bus_s.start = 1'b0; bus_s.len = '0; bus_s.din_valid = 1'b0; bus_s.din = '0;
    @(negedge clk);
    test_reset;
    test_clean;
    test_single_error;
    test_gapped;
    test_selfsync;
    test_saturation;
    test_reset_restart;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lfsr_8b_checker.md
# lfsr_8b_checker

Receive-side pattern checker for the memory-controller BIST path. It regenerates the 8-bit LFSR sequence locally (taps 8,6,5,4; seed 8'h01; left shift with feedback into bit 0) and compares it against words read back from memory. It counts mismatches and captures the first failing word, then reports pass/fail to the BIST/BISR controller.

## Interface
- `LEN_W`, 10: width of the word-count input.
- `CNT_W`, 8: width of the error counter. The counter saturates.
- `clk` in 1: clock. All logic is on the rising edge.
- `rstn` in 1: synchronous, active-low reset.
- `start` in 1: one-cycle pulse. Arms a check run of `len` words. Ignored unless the state is IDLE or DONE.
- `len` in LEN_W: number of words to check. Sampled on `start`.
- `din_valid` in 1: read-data qualifier. Words arrive in order with arbitrary gaps.
- `din` in 8: read-back data word.
- `busy` out 1: high in SYNC and CHECK.
- `done` out 1: single-cycle pulse on entry to DONE.
- `pass` out 1: high when the finished run has `err_cnt==0`. Valid from `done` until the next `start`.
- `err_cnt` out CNT_W: count of mismatches. Saturates at all-ones.
- `first_err_idx` out LEN_W: index of the first mismatching word.
- `first_err_data` out 8: received value of the first mismatching word.
- `first_err_exp` out 8: expected value of the first mismatching word.

## Operation
- States: IDLE, SYNC, CHECK, DONE. The encoding lives in the package.
- **IDLE/DONE, `start`=1:**
  - Latch `len`, clear `idx`, `err_cnt`, the `first_err_*` outputs, `pass` and the captured flag.
  - Load the expected register `exp` with 8'h01.
  - Go to SYNC if self-sync is compiled in, else CHECK.
  - If `len`==0, go directly to DONE with `pass`=1.
- **SYNC** (see Configuration): the first valid word loads `exp`. `idx` increments and the state goes to CHECK. If that is also the last word, go to DONE.
- **CHECK, `din_valid`=1:**
  - Compare `din` with `exp`.
  - On mismatch, increment `err_cnt` (saturating). If the captured flag is clear, record `idx`/`din`/`exp` and set the flag.
  - Always advance `exp` to {exp[6:0], exp[7]^exp[5]^exp[4]^exp[3]} and increment `idx`.
  - When `idx`==`len`-1, go to DONE.
- **DONE:** `done` pulses for one cycle. `pass`=(`err_cnt`==0) is registered and held. The block stays in DONE until `start`.
- `din_valid` in IDLE or DONE is ignored. No counters move.
- `start` in SYNC or CHECK is ignored. The run continues.
- Generated sequence from 8'h01: 01, 02, 04, 08, 11, 23, …

## Timing
- Reset values: state=IDLE, `busy`=0, `done`=0, `pass`=0, `err_cnt`=0, all `first_err_*`=0, `exp`=8'h01.
- All outputs are registered.
- `err_cnt` and `first_err_*` update on the edge that accepts the word. They are visible the following cycle.
- `done` and `pass` assert on the cycle after the last word's accepting edge.
- `busy` rises on the cycle after `start`.
- For `len`==0, `done` asserts on the cycle after `start`.
- Gaps in `din_valid` freeze `exp` and `idx`. Back-to-back valid words are accepted every cycle, with no backpressure.
- Reset mid-run: `rstn` low at an edge returns every register to its reset value. A partial result is never reported.
- Saturation: once `err_cnt` is all-ones it stays there. `pass` stays 0.

## Configuration
- Macro `LFSR_CHK_SELFSYNC_EN`.
- **Defined:** SYNC state exists.
  - The first valid word is not compared. It seeds `exp`, which then advances once.
  - If the seed word is 8'h00 (the LFSR lock-up value), it is counted as one error, captured at index 0 with `first_err_exp`=8'h01, and `exp` is loaded with 8'h02.
- **Undefined:** SYNC is removed. `start` goes straight to CHECK with `exp`=8'h01, and word 0 is compared.

## Structure
- Package `lfsr_chk_pkg` holds:
  - the state enum
  - `LFSR_SEED`=8'h01
  - the tap mask constant
  - a pure next-value function shared with the generator
- One sub-module, `lfsr_8b_exp`: the expected-value register with `load`/`advance` controls. The checker FSM, counters and capture logic stay in the top.

## Test plan
- **Clean run, macro off:** `len`=6, data 01,02,04,08,11,23 back-to-back. Expect `done` one cycle after the last word, `pass`=1, `err_cnt`=0.
- **Single error:** same run with word 3 = 8'h09. Expect `err_cnt`=1, `first_err_idx`=3, `first_err_data`=09, `first_err_exp`=08, `pass`=0.
- **Gapped stream:** same clean data with `din_valid` low for 2 cycles between each word. Expect `pass`=1, and `done` one cycle after the sixth word.
- **Self-sync, macro on:** `len`=4, data 11,23,47,8E. Expect `pass`=1. Then rerun with first word 00. Expect `err_cnt`≥1 and `first_err_idx`=0.
- **Saturation:** `CNT_W`=2, `len`=8, all words 8'hFF. Expect `err_cnt`=3 and `pass`=0.
- **Reset and restart:** pull `rstn` low mid-run. Expect IDLE and zeroed outputs next cycle. `start` with `len`=0 gives `done` the next cycle with `pass`=1.
